// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and start in, status and result out.
interface alu_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] ac;
    logic [WIDTH-1:0] dr;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             e;

    modport master (output start, mode, ac, dr, input busy, done, result, e);
    modport slave  (input start, mode, ac, dr, output busy, done, result, e);
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: seven single-cycle ops plus a WIDTH-cycle unsigned shift-add multiply.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    alu_seq_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               e_q, e_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        e_d      = e_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sum      = {1'b0, bus.ac} + {1'b0, bus.dr};
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    done_d = 1'b1;
                    case (bus.mode)
                        3'b000: begin result_d = sum[WIDTH-1:0];         e_d = sum[WIDTH];        end
                        3'b001: begin result_d = bus.dr << 1;            e_d = bus.dr[WIDTH-1];   end
                        3'b010: begin result_d = ~(bus.ac ^ bus.dr);                              end
                        3'b011: begin result_d = bus.dr >> 1;            e_d = bus.dr[0];         end
                        3'b100: begin result_d = bus.dr;                                          end
                        3'b101: begin result_d = bus.ac;                                          end
                        3'b110: begin result_d = ~bus.dr + WIDTH'(1);    e_d = (bus.dr == '0);    end
                        default: begin
                            // Multiply: operands are latched here so later input changes are ignored
                            done_d   = 1'b0;
                            state_d  = MUL;
                            mcand_d  = {{WIDTH{1'b0}}, bus.ac};
                            mplier_d = bus.dr;
                            acc_d    = '0;
                            cnt_d    = '0;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = acc_next[WIDTH-1:0];
                    e_d      = |acc_next[2*WIDTH-1:WIDTH];
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            e_q      <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            e_q      <= e_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy   = (state_q == MUL);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.e      = e_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, directed corner sequences, random ops vs. arithmetic model.
module tb_alu_seq;
    localparam int W = 8;
    localparam int unsigned M = 1 << W;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [W-1:0] m_r;
    logic         m_e;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   m;
        logic [W-1:0] a;
        logic [W-1:0] d;
        logic [W-1:0] r;
        logic         e;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operation definitions
    function automatic logic [W:0] model(input logic [2:0] m, input logic [W-1:0] a,
                                         input logic [W-1:0] d, input logic ep);
        int unsigned ai, di, r, p;
        logic e;
        ai = a; di = d; e = ep; r = 0;
        case (m)
            3'd0: begin p = ai + di; r = p % M; e = (p >= M); end
            3'd1: begin r = (di * 2) % M; e = (di >= M / 2); end
            3'd2: begin r = (M - 1) - (ai ^ di); end
            3'd3: begin r = di / 2; e = (di % 2) == 1; end
            3'd4: begin r = di; end
            3'd5: begin r = ai; end
            3'd6: begin r = (M - di) % M; e = (di == 0); end
            default: begin p = ai * di; r = p % M; e = (p >= M); end
        endcase
        return {e, W'(r)};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_done", bus.done, 0);
            chk("idle_result", bus.result, m_r);
            chk("idle_e", bus.e, m_e);
        end
    endtask

    task automatic do_op(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] d,
                         input logic [W-1:0] er, input logic ee, input string nm);
        int cyc, nbusy;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.ac = a; bus.dr = d;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0; nbusy = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) nbusy++;
            chk({nm, "_hold_r"}, bus.result, m_r);
            chk({nm, "_hold_e"}, bus.e, m_e);
            // Hammer the inputs mid-flight; none of it may leak into the result
            bus.start = 1'($urandom_range(0, 1));
            bus.mode  = 3'($urandom);
            bus.ac    = $urandom_range(0, 1) ? '1 : W'($urandom);
            bus.dr    = $urandom_range(0, 1) ? '1 : W'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        chk({nm, "_latency"}, cyc, (m == 3'd7) ? W : 0);
        chk({nm, "_busy_cycles"}, nbusy, (m == 3'd7) ? W : 0);
        chk({nm, "_result"}, bus.result, er);
        chk({nm, "_e"}, bus.e, ee);
        chk({nm, "_busy_at_done"}, bus.busy, 0);
        m_r = er; m_e = ee;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] ex;
        logic [2:0] rm;
        logic [W-1:0] ra, rd;

        tbl[0]  = '{3'd0, 8'hF0, 8'h20, 8'h10, 1'b1};
        tbl[1]  = '{3'd2, 8'hAA, 8'h0F, 8'h5A, 1'b1};
        tbl[2]  = '{3'd4, 8'h11, 8'h3C, 8'h3C, 1'b1};
        tbl[3]  = '{3'd5, 8'h77, 8'h00, 8'h77, 1'b1};
        tbl[4]  = '{3'd3, 8'h00, 8'h02, 8'h01, 1'b0};
        tbl[5]  = '{3'd2, 8'h00, 8'h00, 8'hFF, 1'b0};
        tbl[6]  = '{3'd1, 8'h00, 8'h40, 8'h80, 1'b0};
        tbl[7]  = '{3'd6, 8'h00, 8'h01, 8'hFF, 1'b0};
        tbl[8]  = '{3'd6, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[9]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1};
        tbl[10] = '{3'd0, 8'h01, 8'h02, 8'h03, 1'b0};
        tbl[11] = '{3'd7, 8'h12, 8'h0F, 8'h0E, 1'b1};
        tbl[12] = '{3'd7, 8'h03, 8'h05, 8'h0F, 1'b0};
        tbl[13] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 1'b1};

        // Reset with start asserted must still leave everything cleared
        rst = 1'b1; bus.start = 1'b1; bus.mode = 3'd7; bus.ac = 8'h12; bus.dr = 8'h34;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_e", bus.e, 0);
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        m_r = '0; m_e = 1'b0;
        idle(2);

        for (int i = 0; i < 14; i++)
            do_op(tbl[i].m, tbl[i].a, tbl[i].d, tbl[i].r, tbl[i].e, $sformatf("vec%0d", i));
        idle(1);

        // Back-to-back single-cycle ops on consecutive edges
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd1; bus.dr = 8'h81; bus.ac = 8'h00;
        @(posedge clk); #1;
        chk("b2b0_done", bus.done, 1); chk("b2b0_r", bus.result, 8'h02); chk("b2b0_e", bus.e, 1);
        bus.mode = 3'd3; bus.dr = 8'h03;
        @(posedge clk); #1;
        chk("b2b1_done", bus.done, 1); chk("b2b1_r", bus.result, 8'h01); chk("b2b1_e", bus.e, 1);
        bus.mode = 3'd6; bus.dr = 8'h00;
        @(posedge clk); #1;
        chk("b2b2_done", bus.done, 1); chk("b2b2_r", bus.result, 8'h00); chk("b2b2_e", bus.e, 1);
        bus.start = 1'b0;
        m_r = 8'h00; m_e = 1'b1;
        idle(20);

        // Reset sampled on the 4th multiply cycle aborts with no done
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd7; bus.ac = 8'h12; bus.dr = 8'h0F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("abort_busy", bus.busy, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_nodone", bus.done, 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy_rst", bus.busy, 0);
        chk("abort_done_rst", bus.done, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_e", bus.e, 0);
        m_r = '0; m_e = 1'b0;
        idle(12);
        ex = model(3'd2, 8'hAA, 8'h0F, m_e);
        do_op(3'd2, 8'hAA, 8'h0F, ex[W-1:0], ex[W], "post_abort_xnor");

        // Random ops against the arithmetic model, with occasional idle gaps
        for (int i = 0; i < 150; i++) begin
            rm = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom);
            ra = W'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            ex = model(rm, ra, rd, m_e);
            do_op(rm, ra, rd, ex[W-1:0], ex[W], $sformatf("rnd%0d_m%0d", i, rm));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
